// File: rtl/dequantization_unit.sv
// Dequantization unit: turns int4/int8/int16 quantized values back into signed
// 16-bit fixed-point results via (q - zero_point) * scale, rounding and
// saturation. Three-stage pipeline with valid/ready on both sides, a global
// stall (no bubble collapsing) and a sticky saturation counter.
module dequantization_unit #(
  parameter int FRAC_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data_in,
  input  logic        valid_in,
  output logic        ready_in,
  output logic [15:0] data_out,
  output logic        valid_out,
  input  logic        ready_out,
  input  logic [15:0] scale,
  input  logic [15:0] zero_point,
  input  logic [1:0]  input_bits,
  output logic        sat_out,
  output logic [15:0] sat_count,
  input  logic        clear_stats,
  output logic        busy
);

  localparam logic signed [33:0] LP_MAX_POS = 34'sd32767;
  localparam logic signed [33:0] LP_MIN_NEG = -34'sd32768;

  // Pipeline state
  logic               r_v1;
  logic               r_v2;
  logic               r_v3;
  logic signed [16:0] r_diff;
  logic signed [15:0] r_scale;
  logic signed [32:0] r_prod;
  logic [15:0]        r_data_out;
  logic               r_sat;
  logic [15:0]        r_sat_count;

  // Combinational datapath
  logic               w_advance;
  logic signed [16:0] w_q;
  logic signed [16:0] w_zp;
  logic signed [16:0] w_diff;
  logic signed [32:0] w_diff_x;
  logic signed [32:0] w_scale_x;
  logic signed [32:0] w_prod;
  logic signed [33:0] w_prod_x;
  logic signed [33:0] w_rnd;
  logic [15:0]        w_result;
  logic               w_sat;

  // Whole pipeline moves together; it only freezes when the output is blocked.
  assign w_advance = !r_v3 || ready_out;
  assign ready_in  = w_advance;
  assign busy      = r_v1 | r_v2 | r_v3;
  assign valid_out = r_v3;
  assign data_out  = r_data_out;
  assign sat_out   = r_sat;
  assign sat_count = r_sat_count;

  // Select and sign-extend the quantized field; upper bits are ignored for int4/int8.
  always_comb begin
    w_q = 17'sd0;
    case (input_bits)
      2'd0:    w_q = {{9{data_in[7]}}, data_in[7:0]};
      2'd2:    w_q = {{13{data_in[3]}}, data_in[3:0]};
      default: w_q = {data_in[15], data_in};
    endcase
  end

  assign w_zp   = {zero_point[15], zero_point};
  assign w_diff = w_q - w_zp;

  // Stage 1: capture the zero-point-corrected value and the scale that travels with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_diff  <= '0;
      r_scale <= '0;
    end else if (w_advance) begin
      r_v1    <= valid_in;
      r_diff  <= w_diff;
      r_scale <= scale;
    end
  end

  // Exact 17x16 signed product; both operands widened so the 33-bit result is never truncated.
  assign w_diff_x  = {{16{r_diff[16]}}, r_diff};
  assign w_scale_x = {{17{r_scale[15]}}, r_scale};
  assign w_prod    = w_diff_x * w_scale_x;

  // Stage 2: register the product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2   <= 1'b0;
      r_prod <= '0;
    end else if (w_advance) begin
      r_v2   <= r_v1;
      r_prod <= w_prod;
    end
  end

  // One guard bit so adding the rounding constant can never wrap.
  assign w_prod_x = {r_prod[32], r_prod};

  generate
    if (FRAC_BITS > 0) begin : g_round
      localparam logic signed [33:0] LP_HALF = 34'sd1 <<< (FRAC_BITS - 1);
      // Round half toward +inf, then drop the fractional bits arithmetically.
      assign w_rnd = (w_prod_x + LP_HALF) >>> FRAC_BITS;
    end else begin : g_noround
      assign w_rnd = w_prod_x;
    end
  endgenerate

  // Clamp to the signed 16-bit range and flag the clamp.
  always_comb begin
    w_result = w_rnd[15:0];
    w_sat    = 1'b0;
    if (w_rnd > LP_MAX_POS) begin
      w_result = 16'h7FFF;
      w_sat    = 1'b1;
    end else if (w_rnd < LP_MIN_NEG) begin
      w_result = 16'h8000;
      w_sat    = 1'b1;
    end
  end

  // Stage 3: output register, held while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v3       <= 1'b0;
      r_data_out <= '0;
      r_sat      <= 1'b0;
    end else if (w_advance) begin
      r_v3       <= r_v2;
      r_data_out <= w_result;
      r_sat      <= w_sat;
    end
  end

  // Count delivered saturated beats; sticks at all-ones, clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_count <= '0;
    end else if (clear_stats) begin
      r_sat_count <= '0;
    end else if (r_v3 && ready_out && r_sat && (r_sat_count != 16'hFFFF)) begin
      r_sat_count <= r_sat_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_dequantization_unit.sv
// Directed self-checking bench for dequantization_unit (FRAC_BITS=8).
module tb_dequantization_unit;

  logic        clk;
  logic        rst_n;
  logic [15:0] data_in;
  logic        valid_in;
  logic        ready_in;
  logic [15:0] data_out;
  logic        valid_out;
  logic        ready_out;
  logic [15:0] scale;
  logic [15:0] zero_point;
  logic [1:0]  input_bits;
  logic        sat_out;
  logic [15:0] sat_count;
  logic        clear_stats;
  logic        busy;

  int checks;
  int failures;
  logic [15:0] got_q[$];

  dequantization_unit #(.FRAC_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
    .ready_in(ready_in), .data_out(data_out), .valid_out(valid_out),
    .ready_out(ready_out), .scale(scale), .zero_point(zero_point),
    .input_bits(input_bits), .sat_out(sat_out), .sat_count(sat_count),
    .clear_stats(clear_stats), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every output handshake (values are stable at the falling edge).
  always @(negedge clk) begin
    if (rst_n && valid_out && ready_out) got_q.push_back(data_out);
  end

  // Drive one beat into an idle pipeline, wait for its output, optionally
  // assert clear_stats during the output handshake cycle.
  task automatic send_one(input logic [15:0] d, input logic [15:0] zp,
                          input logic [15:0] sc, input logic [1:0] bits,
                          input logic clr, output logic [15:0] res,
                          output logic sat, output int lat);
    data_in = d; zero_point = zp; scale = sc; input_bits = bits; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    lat = 1;
    while (!valid_out && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = data_out;
    sat = sat_out;
    if (clr) clear_stats = 1'b1;
    @(posedge clk); #1;
    clear_stats = 1'b0;
    $display("beat data_in=%h zp=%h scale=%h bits=%0d -> data_out=%h sat=%0b lat=%0d",
             d, zp, sc, bits, res, sat, lat);
  endtask

  task automatic test_reset();
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid_out got=%b exp=0", valid_out); end
    checks++; if (data_out !== 16'h0000) begin failures++; $display("FAIL reset_data_out got=%h exp=0000", data_out); end
    checks++; if (ready_in !== 1'b1) begin failures++; $display("FAIL reset_ready_in got=%b exp=1", ready_in); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (sat_count !== 16'h0000) begin failures++; $display("FAIL reset_sat_count got=%h exp=0000", sat_count); end
    $display("reset state checked");
  endtask

  task automatic test_int8();
    logic [15:0] r; logic s; int lat;
    send_one(16'h0085, 16'h0003, 16'h0100, 2'd0, 1'b0, r, s, lat);
    checks++; if (r !== 16'hFF82) begin failures++; $display("FAIL int8_data got=%h exp=ff82", r); end
    checks++; if (s !== 1'b0) begin failures++; $display("FAIL int8_sat got=%b exp=0", s); end
    checks++; if (lat != 3) begin failures++; $display("FAIL int8_latency got=%0d exp=3", lat); end
    // Upper bits of data_in must be ignored in int8 mode
    send_one(16'hA585, 16'h0003, 16'h0100, 2'd0, 1'b0, r, s, lat);
    checks++; if (r !== 16'hFF82) begin failures++; $display("FAIL int8_upper_ignored got=%h exp=ff82", r); end
  endtask

  task automatic test_rounding();
    logic [15:0] din [3] = '{16'h0003, 16'hFFFD, 16'h0004};
    logic [15:0] exp_v [3] = '{16'h0002, 16'hFFFF, 16'h0002};
    logic [15:0] r; logic s; int lat;
    for (int i = 0; i < 3; i++) begin
      send_one(din[i], 16'h0000, 16'h0080, 2'd1, 1'b0, r, s, lat);
      checks++; if (r !== exp_v[i]) begin failures++; $display("FAIL round_%0d got=%h exp=%h", i, r, exp_v[i]); end
    end
  endtask

  task automatic test_saturation();
    logic [15:0] r; logic s; int lat;
    rst_n = 1'b0; #2; rst_n = 1'b1;
    @(posedge clk); #1;
    send_one(16'h7FFF, 16'h8000, 16'h0200, 2'd1, 1'b0, r, s, lat);
    checks++; if (r !== 16'h7FFF || s !== 1'b1) begin failures++; $display("FAIL sat_pos got=%h/%b exp=7fff/1", r, s); end
    send_one(16'h8000, 16'h7FFF, 16'h0100, 2'd3, 1'b0, r, s, lat);
    checks++; if (r !== 16'h8000 || s !== 1'b1) begin failures++; $display("FAIL sat_neg got=%h/%b exp=8000/1", r, s); end
    checks++; if (sat_count !== 16'd2) begin failures++; $display("FAIL sat_count got=%0d exp=2", sat_count); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [15:0] held;
    got_q.delete();
    ready_out = 1'b1;
    fork
      begin : drv
        for (int k = 1; k <= 5; k++) begin
          bit acc;
          int tries;
          data_in = 16'hFFF0 | 16'(k); zero_point = 16'h0; scale = 16'h0100;
          input_bits = 2'd2; valid_in = 1'b1;
          acc = 1'b0; tries = 0;
          while (!acc && tries < 40) begin
            @(negedge clk);
            acc = ready_in;
            @(posedge clk); #1;
            tries++;
          end
        end
        valid_in = 1'b0;
      end
      begin : ctl
        cyc = 0;
        while (!valid_out && cyc < 20) begin @(posedge clk); #1; cyc++; end
        ready_out = 1'b0;
        held = data_out;
        checks++; if (held !== 16'h0001) begin failures++; $display("FAIL bp_first got=%h exp=0001", held); end
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          checks++; if (ready_in !== 1'b0) begin failures++; $display("FAIL bp_ready_in_c%0d got=%b exp=0", c, ready_in); end
          checks++; if (data_out !== held || valid_out !== 1'b1) begin failures++; $display("FAIL bp_hold_c%0d got=%h/%b exp=%h/1", c, data_out, valid_out, held); end
          @(posedge clk); #1;
        end
        ready_out = 1'b1;
      end
    join
    cyc = 0;
    while (got_q.size() < 5 && cyc < 30) begin @(posedge clk); #1; cyc++; end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (got_q.size() != 5) begin failures++; $display("FAIL bp_count got=%0d exp=5", got_q.size()); end
    for (int k = 0; k < 5 && k < got_q.size(); k++) begin
      checks++; if (got_q[k] !== 16'(k + 1)) begin failures++; $display("FAIL bp_order_%0d got=%h exp=%h", k, got_q[k], 16'(k + 1)); end
      $display("bp out[%0d]=%h", k, got_q[k]);
    end
  endtask

  task automatic test_reset_midstream();
    logic [15:0] r; logic s; int lat;
    ready_out = 1'b1;
    input_bits = 2'd1; zero_point = 16'h8000; scale = 16'h0200; valid_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      data_in = 16'h7FFF;
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    rst_n = 1'b0;
    #1;
    got_q.delete();
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b exp=0", valid_out); end
    checks++; if (data_out !== 16'h0) begin failures++; $display("FAIL rst_mid_data got=%h exp=0000", data_out); end
    checks++; if (sat_count !== 16'h0) begin failures++; $display("FAIL rst_mid_sat_count got=%h exp=0000", sat_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (got_q.size() != 0 || busy !== 1'b0) begin failures++; $display("FAIL rst_mid_stale got=%0d beats busy=%b exp=0/0", got_q.size(), busy); end
    send_one(16'h0010, 16'h0000, 16'h0100, 2'd1, 1'b0, r, s, lat);
    checks++; if (r !== 16'h0010 || lat != 3) begin failures++; $display("FAIL rst_mid_next got=%h lat=%0d exp=0010 lat=3", r, lat); end
  endtask

  task automatic test_stats();
    logic [15:0] r; logic s; int lat;
    send_one(16'h7FFF, 16'h8000, 16'h0200, 2'd1, 1'b0, r, s, lat);
    checks++; if (sat_count !== 16'd1) begin failures++; $display("FAIL stats_pre got=%0d exp=1", sat_count); end
    send_one(16'h7FFF, 16'h8000, 16'h0200, 2'd1, 1'b1, r, s, lat);
    checks++; if (sat_count !== 16'd0) begin failures++; $display("FAIL stats_clear_wins got=%0d exp=0", sat_count); end
    send_one(16'h8000, 16'h7FFF, 16'h0100, 2'd1, 1'b0, r, s, lat);
    checks++; if (sat_count !== 16'd1) begin failures++; $display("FAIL stats_after_clear got=%0d exp=1", sat_count); end
    // A non-saturating beat leaves the counter alone
    send_one(16'h0002, 16'h0000, 16'h0100, 2'd2, 1'b0, r, s, lat);
    checks++; if (sat_count !== 16'd1 || s !== 1'b0) begin failures++; $display("FAIL stats_nosat got=%0d/%b exp=1/0", sat_count, s); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; data_in = '0; valid_in = 1'b0; ready_out = 1'b1;
    scale = '0; zero_point = '0; input_bits = '0; clear_stats = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_int8();
    test_rounding();
    test_saturation();
    test_back_to_back();
    test_reset_midstream();
    test_stats();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
